pipe_hazard_fwd_unit: RTL and testbench
=======================================

Name: pipe_hazard_fwd_unit

Overview:
Parametrised successor to the single-stage forwarding detector. It tracks the destination register of every in-flight instruction across FWD_DEPTH downstream pipeline stages using an internal shadow pipeline. For each of NUM_SRC decode-stage operands it selects the nearest valid producer. It also detects load-use hazards, generates the decode stall, and keeps a saturating stall counter. It sits beside the decode stage and drives the operand bypass muxes and the fetch/decode hold.

Parameters:
REG_AW, 5, register address width; address 0 is hardwired zero and never forwards.
FWD_DEPTH, 2, number of downstream stages tracked (slot 1 = EX, slot 2 = MEM, ...); legal range 1..7.
NUM_SRC, 2, number of source operands per instruction.
LOAD_LAT, 1, load result is unavailable while the load sits in slots 1..LOAD_LAT; must be less than FWD_DEPTH.
SELW, 3, forward-select width; must satisfy 2^SELW > FWD_DEPTH.
CNT_W, 16, stall counter width.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  asynchronous, active-low reset
id_valid  in  1  decode holds a valid instruction
id_aa  in  NUM_SRC*REG_AW  source register addresses; operand i occupies bits [i*REG_AW +: REG_AW]
id_use  in  NUM_SRC  operand i reads a register (inverse of constant/immediate select)
id_da  in  REG_AW  decode-stage destination address
id_rw  in  1  decode instruction writes the register file
id_is_load  in  1  decode instruction is a load
flush  in  1  kill the decode instruction (branch taken)
fwd_sel  out  NUM_SRC*SELW  per operand: 0 = register file, k = bypass from slot k
stall  out  1  hold PC and decode; insert a bubble
stall_cnt  out  CNT_W  saturating count of stall cycles

Behaviour:
- Shadow pipeline: slots 1..FWD_DEPTH, each holding {v, da, rw, ld}. State is registered; fwd_sel and stall are combinational from slot state and decode inputs.
- Slot match for operand i at slot k: v_k & rw_k & (da_k != 0) & id_use[i] & id_valid & (da_k == aa_i).
- fwd_sel_i is the smallest k with a slot match. If no slot matches, fwd_sel_i = 0. The nearest producer always wins over older ones.
- Load-use: stall = 1 if any operand's winning match k has ld_k = 1 and k <= LOAD_LAT.
  - While stalled, fwd_sel still reports the winning k. Consumers ignore it during stall.
- Stall is overridden by flush: if flush = 1, stall = 0, because a killed instruction cannot stall.
- Clock edge, shift behaviour:
  - Slot k <= slot k-1 for k >= 2, every cycle, unconditionally. Downstream stages never stall.
  - Slot 1 <= {id_valid, id_da, id_rw, id_is_load} if id_valid & ~stall & ~flush; otherwise slot 1 <= bubble (v = 0).
- stall_cnt increments on every cycle with stall = 1. It saturates at all-ones and never wraps.
- Reset (reset_n = 0, asynchronous): all slot v = 0, all slot fields = 0, stall_cnt = 0.
  - As a result, fwd_sel = 0 and stall = 0 during and immediately after reset.
  - Reset asserted mid-stall clears the state; the stalled instruction re-evaluates against empty slots.
- Simultaneous events:
  - Both operands may match different slots and are evaluated independently.
  - Both operands matching the same load produce a single stall.
  - flush and stall in the same cycle: flush wins, and slot 1 gets a bubble.
- Latency: a producer issued in cycle N is visible as a slot-1 match in cycle N+1 and as a slot-k match in cycle N+k. It is no longer tracked from cycle N+FWD_DEPTH+1; the register file supplies the value from then on.
- Width rules: the address compare is a full REG_AW-bit equality. fwd_sel values above FWD_DEPTH are never produced.

Decomposition:
- Shared package (risc_pkg):
  - REG_AW
  - slot record typedef {v, da, rw, ld}
  - FWD_SEL_RF = 0 constant
  - function clog2 used to check SELW.
- One natural sub-module: hazard_src_match. Per-operand priority comparator over all slots, returning {hit, sel, is_load_hit}. It is instantiated NUM_SRC times in a generate loop.

Test Plan:
- Reset: hold reset_n = 0 mid-stream with all slots valid -> all fwd_sel = 0, stall = 0, stall_cnt = 0 asynchronously, before the next clk edge.
- Back-to-back ALU dependency: issue ADD R3; next cycle, decode aa0 = 3, id_use = 2'b01 -> fwd_sel[0] = 1. One cycle later, with an unrelated instruction in between, fwd_sel[0] = 2. A further cycle later -> 0.
- Priority: write R5 in cycles N and N+1; decode reads R5 in N+2 -> fwd_sel = 1 (newest), not 2.
- Load-use: LOAD R7, then decode aa1 = 7 -> stall = 1 for exactly 1 cycle and stall_cnt = 1. The next cycle gives stall = 0 and fwd_sel[1] = 2.
- R0 and immediate: producer writes R0, consumer reads R0 -> fwd_sel = 0. Producer writes R4, consumer has aa0 = 4 but id_use[0] = 0 -> fwd_sel[0] = 0.
- Flush vs stall: LOAD R2, then decode reads R2 with flush = 1 -> stall = 0, and slot 1 is a bubble on the next cycle. Separately, force 2^16 + 3 stall cycles -> stall_cnt = 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_fwd_unit_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
package pipe_hazard_fwd_unit_pkg;

    // Register address width the slot record is built for.
    localparam int unsigned DFLT_REG_AW   = 5;
    // Deepest downstream pipeline the unit can track.
    localparam int unsigned MAX_FWD_DEPTH = 7;
    // Forward-select code meaning "take the operand from the register file".
    localparam int unsigned FWD_SEL_RF    = 0;

    // One in-flight instruction as seen by the hazard logic.
    typedef struct packed {
        logic                   v;
        logic [DFLT_REG_AW-1:0] da;
        logic                   rw;
        logic                   ld;
    } slot_t;

    // Ceiling log2, used to size-check the forward-select width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) begin
                r = 32'(i + 1);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_fwd_unit_if.sv
// Decode-side bundle between the decode stage and the hazard unit.
interface pipe_hazard_fwd_unit_if #(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned SELW    = 3,
    parameter int unsigned CNT_W   = 16
);
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_aa;
    logic [NUM_SRC-1:0]        id_use;
    logic [REG_AW-1:0]         id_da;
    logic                      id_rw;
    logic                      id_is_load;
    logic                      flush;
    logic [NUM_SRC*SELW-1:0]   fwd_sel;
    logic                      stall;
    logic [CNT_W-1:0]          stall_cnt;

    // Decode stage drives the instruction, receives bypass selects and hold.
    modport master (
        output id_valid, id_aa, id_use, id_da, id_rw, id_is_load, flush,
        input  fwd_sel, stall, stall_cnt
    );

    // Hazard unit side.
    modport slave (
        input  id_valid, id_aa, id_use, id_da, id_rw, id_is_load, flush,
        output fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_fwd_unit_src_match.sv
// Per-operand priority comparator: finds the nearest in-flight producer.
module hazard_src_match
    import pipe_hazard_fwd_unit_pkg::*;
#(
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned SELW      = 3
) (
    input  slot_t [FWD_DEPTH-1:0]   i_slots,
    input  logic [DFLT_REG_AW-1:0]  i_aa,
    input  logic                    i_use,
    input  logic                    i_valid,
    output logic                    o_hit_c,
    output logic [SELW-1:0]         o_sel_c,
    output logic                    o_ld_hit_c
);

    // Scan oldest to newest so the youngest matching slot is the last write.
    always_comb begin
        o_hit_c    = 1'b0;
        o_sel_c    = SELW'(FWD_SEL_RF);
        o_ld_hit_c = 1'b0;
        if (i_valid && i_use) begin
            for (int k = int'(FWD_DEPTH) - 1; k >= 0; k--) begin
                if (i_slots[k].v && i_slots[k].rw &&
                    (i_slots[k].da != '0) && (i_slots[k].da == i_aa)) begin
                    o_hit_c    = 1'b1;
                    o_sel_c    = SELW'(k + 1);
                    o_ld_hit_c = i_slots[k].ld;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_fwd_unit.sv
// Multi-stage operand forwarding selector with load-use stall detection.
module pipe_hazard_fwd_unit
    import pipe_hazard_fwd_unit_pkg::*;
#(
    parameter int unsigned REG_AW    = DFLT_REG_AW,
    parameter int unsigned FWD_DEPTH = 2,
    parameter int unsigned NUM_SRC   = 2,
    parameter int unsigned LOAD_LAT  = 1,
    parameter int unsigned SELW      = 3,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    pipe_hazard_fwd_unit_if.slave  bus
);

    // Reject parameter sets the select encoding or slot record cannot hold.
    if (REG_AW != DFLT_REG_AW) begin : g_bad_aw
        $error("REG_AW must match the slot record address width");
    end
    if ((FWD_DEPTH < 1) || (FWD_DEPTH > MAX_FWD_DEPTH)) begin : g_bad_depth
        $error("FWD_DEPTH out of range 1..7");
    end
    if (LOAD_LAT >= FWD_DEPTH) begin : g_bad_lat
        $error("LOAD_LAT must be less than FWD_DEPTH");
    end
    if (clog2(FWD_DEPTH + 1) > SELW) begin : g_bad_selw
        $error("SELW too narrow to encode every slot");
    end

    slot_t [FWD_DEPTH-1:0]     r_slots;
    logic [CNT_W-1:0]          r_stall_cnt;
    logic [NUM_SRC-1:0]        w_hit;
    logic [NUM_SRC-1:0]        w_ld_hit;
    logic [NUM_SRC-1:0]        w_load_use;
    logic [NUM_SRC*SELW-1:0]   w_sel;
    logic                      w_stall;
    logic                      w_issue;

    // One comparator per decode operand; operands resolve independently.
    for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_src
        hazard_src_match #(
            .FWD_DEPTH (FWD_DEPTH),
            .SELW      (SELW)
        ) u_match (
            .i_slots    (r_slots),
            .i_aa       (bus.id_aa[i*REG_AW +: REG_AW]),
            .i_use      (bus.id_use[i]),
            .i_valid    (bus.id_valid),
            .o_hit_c    (w_hit[i]),
            .o_sel_c    (w_sel[i*SELW +: SELW]),
            .o_ld_hit_c (w_ld_hit[i])
        );

        // Winning producer is a load whose data is not back yet.
        assign w_load_use[i] = w_hit[i] & w_ld_hit[i] &
                               (w_sel[i*SELW +: SELW] <= SELW'(LOAD_LAT));
    end

    // A flushed instruction is dead, so it can never hold the front end.
    assign w_stall = (|w_load_use) & ~bus.flush;
    assign w_issue = bus.id_valid & ~w_stall & ~bus.flush;

    assign bus.fwd_sel   = w_sel;
    assign bus.stall     = w_stall;
    assign bus.stall_cnt = r_stall_cnt;

    // Shadow pipeline: decode enters slot 1, downstream slots always advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slots <= '0;
        end else begin
            r_slots[0] <= w_issue ? slot_t'{v: 1'b1, da: bus.id_da,
                                            rw: bus.id_rw, ld: bus.id_is_load}
                                  : slot_t'('0);
            for (int k = 1; k < int'(FWD_DEPTH); k++) begin
                r_slots[k] <= r_slots[k-1];
            end
        end
    end

    // Saturating count of stalled decode cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_fwd_unit.sv
// Self-checking bench: directed table plus random traffic against an issue-log model.
module tb_pipe_hazard_fwd_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       t_valid;
    logic [4:0] t_aa0, t_aa1, t_da;
    logic [1:0] t_use;
    logic       t_rw, t_ld, t_flush;

    // Instance 0: default parameters. Instance 1: deeper, longer load, narrow counter.
    pipe_hazard_fwd_unit_if #(.REG_AW(5), .NUM_SRC(2), .SELW(3), .CNT_W(16)) ifa ();
    pipe_hazard_fwd_unit_if #(.REG_AW(5), .NUM_SRC(2), .SELW(3), .CNT_W(4))  ifb ();

    assign ifa.id_valid = t_valid;  assign ifb.id_valid = t_valid;
    assign ifa.id_aa = {t_aa1, t_aa0}; assign ifb.id_aa = {t_aa1, t_aa0};
    assign ifa.id_use = t_use;      assign ifb.id_use = t_use;
    assign ifa.id_da = t_da;        assign ifb.id_da = t_da;
    assign ifa.id_rw = t_rw;        assign ifb.id_rw = t_rw;
    assign ifa.id_is_load = t_ld;   assign ifb.id_is_load = t_ld;
    assign ifa.flush = t_flush;     assign ifb.flush = t_flush;

    pipe_hazard_fwd_unit #(.REG_AW(5), .FWD_DEPTH(2), .NUM_SRC(2), .LOAD_LAT(1),
                           .SELW(3), .CNT_W(16))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
    pipe_hazard_fwd_unit #(.REG_AW(5), .FWD_DEPTH(3), .NUM_SRC(2), .LOAD_LAT(2),
                           .SELW(3), .CNT_W(4))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a log of what each instance issued in every past cycle.
    typedef struct {
        bit v;
        int da;
        bit rw;
        bit ld;
    } rec_t;

    rec_t log_m [2][8];
    int   cnt_m [2];
    int   depth_m [2] = '{2, 3};
    int   lat_m [2]   = '{1, 2};
    int   cmax_m [2]  = '{65535, 15};
    int   cyc = 0;

    typedef struct {
        bit v; int aa0; int aa1; int use_b; int da; bit rw; bit ld; bit fl;
        int e0; int e1; int es; int ec;
    } vec_t;
    vec_t tab[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int m = 0; m < 2; m++) begin
            cnt_m[m] = 0;
            for (int j = 0; j < 8; j++) log_m[m][j] = '{v: 0, da: 0, rw: 0, ld: 0};
        end
    endfunction

    // Nearest producer issued within the tracked window; stall if still a pending load.
    function automatic void model_eval(input int m, output int s0, output int s1, output int st);
        int aa [2];
        int sel [2];
        rec_t r;
        aa[0] = int'(t_aa0);
        aa[1] = int'(t_aa1);
        st = 0;
        for (int i = 0; i < 2; i++) begin
            sel[i] = 0;
            if (t_valid && t_use[i] && aa[i] != 0) begin
                for (int k = 1; k <= depth_m[m]; k++) begin
                    r = log_m[m][(cyc - k) & 7];
                    if (sel[i] == 0 && r.v && r.rw && r.da == aa[i]) sel[i] = k;
                end
            end
            if (sel[i] != 0) begin
                r = log_m[m][(cyc - sel[i]) & 7];
                if (r.ld && sel[i] <= lat_m[m]) st = 1;
            end
        end
        if (t_flush) st = 0;
        s0 = sel[0];
        s1 = sel[1];
    endfunction

    // One decode cycle: compare at the falling edge, advance the model at the rising edge.
    task automatic step(input bit tabchk, input int e0, input int e1, input int es, input int ec);
        int s0, s1, st;
        int st_s [2];
        logic [2:0]  d0, d1;
        logic        ds;
        logic [15:0] dc;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            model_eval(m, s0, s1, st);
            st_s[m] = st;
            if (m == 0) begin
                d0 = ifa.fwd_sel[2:0]; d1 = ifa.fwd_sel[5:3];
                ds = ifa.stall;        dc = ifa.stall_cnt;
            end else begin
                d0 = ifb.fwd_sel[2:0]; d1 = ifb.fwd_sel[5:3];
                ds = ifb.stall;        dc = 16'(ifb.stall_cnt);
            end
            chk($sformatf("cyc%0d inst%0d sel0", cyc, m), 32'(d0), 32'(s0));
            chk($sformatf("cyc%0d inst%0d sel1", cyc, m), 32'(d1), 32'(s1));
            chk($sformatf("cyc%0d inst%0d stall", cyc, m), 32'(ds), 32'(st));
            chk($sformatf("cyc%0d inst%0d cnt", cyc, m), 32'(dc), 32'(cnt_m[m]));
        end
        if (tabchk) begin
            chk($sformatf("tab cyc%0d sel0", cyc), 32'(ifa.fwd_sel[2:0]), 32'(e0));
            chk($sformatf("tab cyc%0d sel1", cyc), 32'(ifa.fwd_sel[5:3]), 32'(e1));
            chk($sformatf("tab cyc%0d stall", cyc), 32'(ifa.stall), 32'(es));
            chk($sformatf("tab cyc%0d cnt", cyc), 32'(ifa.stall_cnt), 32'(ec));
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (t_valid && !st_s[m] && !t_flush)
                log_m[m][cyc & 7] = '{v: 1, da: int'(t_da), rw: t_rw, ld: t_ld};
            else
                log_m[m][cyc & 7] = '{v: 0, da: 0, rw: 0, ld: 0};
            if (st_s[m] != 0 && cnt_m[m] < cmax_m[m]) cnt_m[m]++;
        end
        cyc++;
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " inst0 fwd_sel"}, 32'(ifa.fwd_sel), 32'd0);
        chk({tag, " inst0 stall"}, 32'(ifa.stall), 32'd0);
        chk({tag, " inst0 cnt"}, 32'(ifa.stall_cnt), 32'd0);
        chk({tag, " inst1 fwd_sel"}, 32'(ifb.fwd_sel), 32'd0);
        chk({tag, " inst1 stall"}, 32'(ifb.stall), 32'd0);
        chk({tag, " inst1 cnt"}, 32'(ifb.stall_cnt), 32'd0);
    endtask

    task automatic drive(input bit v, input int aa0, input int aa1, input int u,
                         input int da, input bit rw, input bit ld, input bit fl);
        t_valid = v;
        t_aa0 = 5'(aa0); t_aa1 = 5'(aa1); t_use = 2'(u);
        t_da = 5'(da); t_rw = rw; t_ld = ld; t_flush = fl;
    endtask

    initial begin
        // {v, aa0, aa1, use, da, rw, ld, flush, exp sel0, exp sel1, exp stall, exp cnt}
        tab.push_back('{1, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0, 0}); // ADD R3
        tab.push_back('{1, 3, 0, 1, 0, 0, 0, 0,  1, 0, 0, 0}); // read R3 from EX
        tab.push_back('{1, 3, 0, 1, 0, 0, 0, 0,  2, 0, 0, 0}); // read R3 from MEM
        tab.push_back('{1, 3, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0}); // aged out
        tab.push_back('{1, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0}); // R5
        tab.push_back('{1, 0, 0, 0, 5, 1, 0, 0,  0, 0, 0, 0}); // R5 again
        tab.push_back('{1, 5, 5, 3, 0, 0, 0, 0,  1, 1, 0, 0}); // newest wins
        tab.push_back('{1, 0, 0, 0, 7, 1, 1, 0,  0, 0, 0, 0}); // LOAD R7
        tab.push_back('{1, 0, 7, 2, 0, 0, 0, 0,  0, 1, 1, 0}); // load-use stall
        tab.push_back('{1, 0, 7, 2, 0, 0, 0, 0,  0, 2, 0, 1}); // released, from MEM
        tab.push_back('{1, 0, 0, 0, 0, 1, 0, 0,  0, 0, 0, 1}); // writes R0
        tab.push_back('{1, 0, 0, 3, 0, 0, 0, 0,  0, 0, 0, 1}); // R0 never forwards
        tab.push_back('{1, 0, 0, 0, 4, 1, 0, 0,  0, 0, 0, 1}); // R4
        tab.push_back('{1, 4, 4, 2, 0, 0, 0, 0,  0, 1, 0, 1}); // op0 immediate
        tab.push_back('{1, 0, 0, 0, 2, 1, 1, 0,  0, 0, 0, 1}); // LOAD R2
        tab.push_back('{1, 2, 0, 1, 9, 1, 0, 1,  1, 0, 0, 1}); // flush beats stall
        tab.push_back('{1, 9, 2, 3, 0, 0, 0, 0,  0, 2, 0, 1}); // flushed R9 absent
        tab.push_back('{1, 0, 0, 0, 10, 1, 0, 0, 0, 0, 0, 1}); // R10
        tab.push_back('{1, 10, 10, 3, 0, 0, 0, 0, 1, 1, 0, 1}); // both ops slot 1
        tab.push_back('{1, 0, 0, 0, 11, 1, 1, 0, 0, 0, 0, 1}); // LOAD R11
        tab.push_back('{1, 11, 11, 3, 0, 0, 0, 0, 1, 1, 1, 1}); // one shared stall
        tab.push_back('{1, 11, 11, 3, 0, 0, 0, 0, 2, 2, 0, 2}); // counted once
        tab.push_back('{1, 0, 0, 0, 12, 1, 0, 0, 0, 0, 0, 2}); // R12
        tab.push_back('{1, 12, 0, 1, 13, 1, 0, 0, 1, 0, 0, 2}); // R13, reads R12
        tab.push_back('{1, 12, 13, 3, 0, 0, 0, 0, 2, 1, 0, 2}); // ops on different slots
        tab.push_back('{0, 13, 0, 1, 0, 0, 0, 0,  0, 0, 0, 2}); // invalid decode

        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("in reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tab[i]) begin
            drive(tab[i].v, tab[i].aa0, tab[i].aa1, tab[i].use_b, tab[i].da,
                  tab[i].rw, tab[i].ld, tab[i].fl);
            step(1'b1, tab[i].e0, tab[i].e1, tab[i].es, tab[i].ec);
        end

        // Asynchronous reset in the middle of a load-use stall.
        drive(1, 0, 0, 0, 7, 1, 1, 0);
        step(1'b0, 0, 0, 0, 0);
        drive(1, 7, 0, 1, 3, 1, 0, 0);
        @(negedge clk);
        chk("pre-reset stall", 32'(ifa.stall), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_zero("async reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_clear();
        step(1'b0, 0, 0, 0, 0);
        step(1'b0, 0, 0, 0, 0);

        // Random traffic over a small register range to provoke collisions.
        repeat (3000) begin
            drive(($urandom % 8) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom % 4), int'($urandom_range(0, 7)), 1'b0, 1'b0,
                  ($urandom % 8) == 0);
            t_rw = 1'($urandom % 2);
            t_ld = t_rw & 1'($urandom % 2);
            step(1'b0, 0, 0, 0, 0);
        end

        // Self-dependent loads keep stalling; the narrow counter must pin at all-ones.
        drive(1, 7, 0, 1, 7, 1, 1, 0);
        repeat (60) step(1'b0, 0, 0, 0, 0);
        chk("inst1 cnt saturated", 32'(ifb.stall_cnt), 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
